// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (processor, program loader), the
// arbiter and a variable-latency memory.
//   Cpu*  : processor request, write enable, address, write data, read data,
//           completion pulse and stall.
//   Ldr*  : program-loader request, write enable, address, write data,
//           read data and completion pulse.
//   Err   : timeout pulse, coincident with the owner's Done.
//   Mem*  : memory request, write enable, address, write data (arbiter side)
//           and read data and ready (memory side).
// Modports:
//   slave  - the arbiter view.
//   master - the environment view (requesters plus memory).
interface mem_arbiter_if #(
  parameter int AW = 32
);
  logic          CpuReq;
  logic          CpuWe;
  logic [AW-1:0] CpuAddr;
  logic [31:0]   CpuWData;
  logic [31:0]   CpuRData;
  logic          CpuDone;
  logic          CpuStall;

  logic          LdrReq;
  logic          LdrWe;
  logic [AW-1:0] LdrAddr;
  logic [31:0]   LdrWData;
  logic [31:0]   LdrRData;
  logic          LdrDone;

  logic          Err;

  logic          MemReq;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [31:0]   MemWData;
  logic [31:0]   MemRData;
  logic          MemReady;

  modport slave (
    input  CpuReq, CpuWe, CpuAddr, CpuWData,
    output CpuRData, CpuDone, CpuStall,
    input  LdrReq, LdrWe, LdrAddr, LdrWData,
    output LdrRData, LdrDone,
    output Err,
    output MemReq, MemWe, MemAddr, MemWData,
    input  MemRData, MemReady
  );

  modport master (
    output CpuReq, CpuWe, CpuAddr, CpuWData,
    input  CpuRData, CpuDone, CpuStall,
    output LdrReq, LdrWe, LdrAddr, LdrWData,
    input  LdrRData, LdrDone,
    input  Err,
    input  MemReq, MemWe, MemAddr, MemWData,
    output MemRData, MemReady
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter with a wait timeout.
// The processor and the program loader share one memory port. One
// transaction is in flight at a time; a memory that never answers is
// abandoned after MAX_WAIT busy cycles with an Err pulse.
// Ports:
//   CLK  - single clock, rising edge.
//   RST  - synchronous, active-high reset.
//   bus  - mem_arbiter_if.slave: requester request/data, per-requester read
//          data and Done pulses, CpuStall, Err, and the registered memory port.
// Parameters:
//   MAX_WAIT - busy cycles allowed without MemReady (2..255).
//   AW       - address width.
module mem_arbiter #(
  parameter int MAX_WAIT = 15,
  parameter int AW       = 32
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  // The counter starts at 0 in the first busy cycle, so MAX_WAIT-1 marks the
  // last busy cycle the memory is given.
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic          owner;      // 0 = processor, 1 = loader
  logic          last_gnt;   // requester granted most recently
  logic [CW-1:0] wait_cnt;

  logic          grant, gnt_ldr, fin_ok, fin_to;

  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_done, ldr_done, err;
  logic [31:0]   cpu_rdata, ldr_rdata;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    gnt_ldr    = 1'b0;
    fin_ok     = 1'b0;
    fin_to     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CpuReq || bus.LdrReq) begin
          grant = 1'b1;
          // On a tie the requester that was not served last wins.
          gnt_ldr    = (bus.CpuReq && bus.LdrReq) ? ~last_gnt : bus.LdrReq;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Ready is tested first so a late answer beats the timeout.
        if (bus.MemReady) begin
          fin_ok     = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          fin_to     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_done  <= 1'b0;
      ldr_done  <= 1'b0;
      err       <= 1'b0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      cpu_done <= (fin_ok || fin_to) && !owner;
      ldr_done <= (fin_ok || fin_to) && owner;
      err      <= fin_to;

      if (grant) begin
        owner     <= gnt_ldr;
        last_gnt  <= gnt_ldr;
        wait_cnt  <= '0;
        mem_req   <= 1'b1;
        mem_we    <= gnt_ldr ? bus.LdrWe    : bus.CpuWe;
        mem_addr  <= gnt_ldr ? bus.LdrAddr  : bus.CpuAddr;
        mem_wdata <= gnt_ldr ? bus.LdrWData : bus.CpuWData;
      end else if (fin_ok || fin_to) begin
        mem_req <= 1'b0;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (fin_ok && !mem_we) begin
        if (owner) ldr_rdata <= bus.MemRData;
        else       cpu_rdata <= bus.MemRData;
      end
    end
  end

  assign bus.MemReq   = mem_req;
  assign bus.MemWe    = mem_we;
  assign bus.MemAddr  = mem_addr;
  assign bus.MemWData = mem_wdata;
  assign bus.CpuDone  = cpu_done;
  assign bus.LdrDone  = ldr_done;
  assign bus.Err      = err;
  assign bus.CpuRData = cpu_rdata;
  assign bus.LdrRData = ldr_rdata;
  assign bus.CpuStall = bus.CpuReq & ~cpu_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are sampled on
// the falling clock edge, away from the rising edge the design uses.
module tb_mem_arbiter;
  localparam int AW       = 32;
  localparam int MAX_WAIT = 15;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.AW(AW)) bus();

  mem_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic idle_inputs;
    bus.CpuReq   = 1'b0;
    bus.CpuWe    = 1'b0;
    bus.CpuAddr  = '0;
    bus.CpuWData = '0;
    bus.LdrReq   = 1'b0;
    bus.LdrWe    = 1'b0;
    bus.LdrAddr  = '0;
    bus.LdrWData = '0;
    bus.MemRData = '0;
    bus.MemReady = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  got_done;

    idle_inputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    // reset state
    chk("rst_memreq",   bus.MemReq,   1'b0);
    chk("rst_memwe",    bus.MemWe,    1'b0);
    chk("rst_memaddr",  bus.MemAddr,  32'h0);
    chk("rst_memwdata", bus.MemWData, 32'h0);
    chk("rst_cpudone",  bus.CpuDone,  1'b0);
    chk("rst_ldrdone",  bus.LdrDone,  1'b0);
    chk("rst_err",      bus.Err,      1'b0);
    chk("rst_cpurdata", bus.CpuRData, 32'h0);
    chk("rst_ldrrdata", bus.LdrRData, 32'h0);
    chk("rst_stall",    bus.CpuStall, 1'b0);
    tick();

    // processor read, ready three cycles after MemReq
    bus.CpuReq  = 1'b1;
    bus.CpuWe   = 1'b0;
    bus.CpuAddr = 32'h100;
    tick();
    chk("rd_memreq",  bus.MemReq,   1'b1);
    chk("rd_memaddr", bus.MemAddr,  32'h100);
    chk("rd_memwe",   bus.MemWe,    1'b0);
    chk("rd_stall",   bus.CpuStall, 1'b1);
    tick();
    chk("rd_nodone1", bus.CpuDone, 1'b0);
    tick();
    chk("rd_nodone2", bus.CpuDone, 1'b0);
    bus.MemReady = 1'b1;
    bus.MemRData = 32'hDEADBEEF;
    tick();
    chk("rd_done",     bus.CpuDone,  1'b1);
    chk("rd_rdata",    bus.CpuRData, 32'hDEADBEEF);
    chk("rd_ldrdone",  bus.LdrDone,  1'b0);
    chk("rd_err",      bus.Err,      1'b0);
    chk("rd_memreq_0", bus.MemReq,   1'b0);
    chk("rd_stall_dn", bus.CpuStall, 1'b0);
    bus.CpuReq   = 1'b0;
    bus.MemReady = 1'b0;
    tick();
    chk("rd_done_1cy", bus.CpuDone, 1'b0);
    chk("rd_idle_req", bus.MemReq,  1'b0);

    // both requesting from reset: CPU, loader, CPU
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.CpuReq   = 1'b1; bus.CpuWe = 1'b1; bus.CpuAddr = 32'h10; bus.CpuWData = 32'hA;
    bus.LdrReq   = 1'b1; bus.LdrWe = 1'b1; bus.LdrAddr = 32'h20; bus.LdrWData = 32'hB;
    bus.MemReady = 1'b1;
    bus.MemRData = 32'h55;
    tick();
    chk("rr1_addr",  bus.MemAddr,  32'h10);
    chk("rr1_wdata", bus.MemWData, 32'hA);
    tick();
    chk("rr1_cpudone", bus.CpuDone, 1'b1);
    chk("rr1_ldrdone", bus.LdrDone, 1'b0);
    tick();
    chk("rr2_addr",  bus.MemAddr,  32'h20);
    chk("rr2_we",    bus.MemWe,    1'b1);
    chk("rr2_stall", bus.CpuStall, 1'b1);
    tick();
    chk("rr2_ldrdone", bus.LdrDone, 1'b1);
    chk("rr2_cpudone", bus.CpuDone, 1'b0);
    tick();
    chk("rr3_addr", bus.MemAddr, 32'h10);
    tick();
    chk("rr3_cpudone", bus.CpuDone, 1'b1);
    bus.CpuReq   = 1'b0;
    bus.LdrReq   = 1'b0;
    bus.MemReady = 1'b0;
    chk("rr_wr_cpurd", bus.CpuRData, 32'h0);
    chk("rr_wr_ldrrd", bus.LdrRData, 32'h0);
    tick();

    // loader write, zero-wait memory
    bus.LdrReq = 1'b1; bus.LdrWe = 1'b1; bus.LdrAddr = 32'h40; bus.LdrWData = 32'h12345678;
    bus.MemReady = 1'b1;
    bus.MemRData = 32'hCAFE;
    tick();
    chk("lw_memreq", bus.MemReq,   1'b1);
    chk("lw_memwe",  bus.MemWe,    1'b1);
    chk("lw_addr",   bus.MemAddr,  32'h40);
    chk("lw_wdata",  bus.MemWData, 32'h12345678);
    chk("lw_early",  bus.LdrDone,  1'b0);
    tick();
    chk("lw_done",    bus.LdrDone,  1'b1);
    chk("lw_memreq0", bus.MemReq,   1'b0);
    chk("lw_ldrrd",   bus.LdrRData, 32'h0);
    chk("lw_cpudone", bus.CpuDone,  1'b0);
    bus.LdrReq = 1'b0;
    tick();

    // loader read only updates the loader's read data
    bus.LdrReq = 1'b1; bus.LdrWe = 1'b0; bus.LdrAddr = 32'h44;
    bus.MemRData = 32'h0BADF00D;
    tick();
    tick();
    chk("lr_done",  bus.LdrDone,  1'b1);
    chk("lr_ldrrd", bus.LdrRData, 32'h0BADF00D);
    chk("lr_cpurd", bus.CpuRData, 32'h0);
    bus.LdrReq   = 1'b0;
    bus.MemReady = 1'b0;
    tick();

    // memory never answers: timeout after MAX_WAIT busy cycles
    bus.CpuReq = 1'b1; bus.CpuWe = 1'b0; bus.CpuAddr = 32'h200;
    bus.MemRData = 32'h1111;
    cnt = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      tick();
      if (bus.MemReq) cnt++;
      if (i == 3) bus.CpuAddr = 32'h300;
      if (i == 5) chk("to_addr_hold", bus.MemAddr, 32'h200);
      if (bus.CpuDone) begin
        got_done = 1'b1;
        chk("to_err",    bus.Err,      1'b1);
        chk("to_cpurd",  bus.CpuRData, 32'h0);
        bus.CpuReq = 1'b0;
      end
    end
    chk("to_done_seen", got_done, 1'b1);
    chk("to_req_cycles", cnt, 15);
    tick();
    chk("to_err_1cy", bus.Err, 1'b0);

    // ready on the last allowed busy cycle wins over the timeout
    bus.CpuReq = 1'b1; bus.CpuAddr = 32'h204;
    bus.MemRData = 32'h600D;
    cnt = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      tick();
      if (bus.MemReq) cnt++;
      if (bus.CpuDone) begin
        got_done = 1'b1;
        chk("late_err",   bus.Err,      1'b0);
        chk("late_cpurd", bus.CpuRData, 32'h600D);
        bus.CpuReq   = 1'b0;
        bus.MemReady = 1'b0;
      end else if (cnt == 15 && bus.MemReq) begin
        bus.MemReady = 1'b1;
      end
    end
    chk("late_done_seen", got_done, 1'b1);
    chk("late_req_cycles", cnt, 15);
    tick();

    // reset in the second busy cycle aborts silently
    bus.CpuReq = 1'b1; bus.CpuWe = 1'b0; bus.CpuAddr = 32'h500;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.CpuReq = 1'b0;
    chk("ab_memreq", bus.MemReq,   1'b0);
    chk("ab_done",   bus.CpuDone,  1'b0);
    chk("ab_err",    bus.Err,      1'b0);
    chk("ab_addr",   bus.MemAddr,  32'h0);
    chk("ab_wdata",  bus.MemWData, 32'h0);
    chk("ab_we",     bus.MemWe,    1'b0);
    chk("ab_cpurd",  bus.CpuRData, 32'h0);
    chk("ab_ldrrd",  bus.LdrRData, 32'h0);
    tick();
    chk("ab_done2", bus.CpuDone, 1'b0);
    chk("ab_err2",  bus.Err,     1'b0);
    bus.CpuReq = 1'b1; bus.CpuAddr = 32'h504;
    bus.MemReady = 1'b1;
    bus.MemRData = 32'h77;
    tick();
    chk("ab_new_addr", bus.MemAddr, 32'h504);
    tick();
    chk("ab_new_done", bus.CpuDone,  1'b1);
    chk("ab_new_rd",   bus.CpuRData, 32'h77);
    bus.CpuReq   = 1'b0;
    bus.MemReady = 1'b0;
    tick();

    // request dropped mid-transaction still completes
    bus.CpuReq = 1'b1; bus.CpuWe = 1'b1; bus.CpuAddr = 32'h600; bus.CpuWData = 32'h99;
    tick();
    chk("dr_stall1", bus.CpuStall, 1'b1);
    chk("dr_memreq", bus.MemReq,   1'b1);
    bus.CpuReq = 1'b0;
    #1;
    chk("dr_stall0", bus.CpuStall, 1'b0);
    tick();
    chk("dr_hold",   bus.MemReq,   1'b1);
    chk("dr_stall2", bus.CpuStall, 1'b0);
    bus.MemReady = 1'b1;
    tick();
    chk("dr_done", bus.CpuDone, 1'b1);
    bus.CpuReq = 1'b1;
    #1;
    chk("dr_stall_done", bus.CpuStall, 1'b0);
    bus.CpuReq   = 1'b0;
    bus.MemReady = 1'b0;
    tick();
    chk("dr_done_1cy", bus.CpuDone, 1'b0);
    chk("dr_idle",     bus.MemReq,  1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of BUSY cycles allowed without MemReady (range 2..255).
REQ-002 The block SHALL have parameter AW, default 32, meaning the address width.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 CpuReq / CpuWe  input  1 each  processor access request / write enable.
REQ-006 CpuAddr  input  AW, CpuWData  input  32  processor address / write data.
REQ-007 LdrReq / LdrWe  input  1 each  program-loader request / write enable.
REQ-008 LdrAddr  input  AW, LdrWData  input  32  loader address / write data.
REQ-009 CpuRData, LdrRData  output  32 each  registered read data per requester.
REQ-010 CpuDone, LdrDone  output  1 each  one-cycle completion pulse per requester.
REQ-011 CpuStall  output  1  combinational CpuReq & ~CpuDone, used to freeze the multicycle FSM.
REQ-012 Err  output  1  one-cycle pulse with Done when a transaction times out.
REQ-013 MemReq, MemWe  output  1 each; MemAddr  output  AW; MemWData  output  32  memory port, all registered.
REQ-014 MemRData  input  32, MemReady  input  1  memory read data and completion (variable latency).

Function
REQ-015 The FSM SHALL have states IDLE and BUSY, plus a 1-bit owner register (0=CPU, 1=loader) and a 1-bit last-granted register.
REQ-016 In IDLE with exactly one request high, that requester SHALL be granted.
REQ-017 In IDLE with both requests high, the requester not equal to last-granted SHALL be granted (round-robin).
REQ-018 On grant, the winner's We/Addr/WData SHALL be latched into MemWe/MemAddr/MemWData, MemReq SHALL go high next cycle, state SHALL go to BUSY, owner and last-granted SHALL be updated.
REQ-019 In BUSY, MemReq and latched Mem* outputs SHALL be held stable until the transaction ends; requester inputs SHALL be ignored.
REQ-020 In BUSY with MemReady high: MemReq SHALL drop next cycle, state -> IDLE, owner's Done SHALL pulse next cycle, and for reads (MemWe=0) owner's RData SHALL load MemRData in that same cycle; the other RData SHALL be unchanged.
REQ-021 Latency: Req sampled in IDLE at cycle n -> MemReq at n+1 -> MemReady at cycle k >= n+1 -> Done/RData at k+1; zero-wait memory gives Done at n+2.
REQ-022 A wait counter SHALL clear on entering BUSY and increment each BUSY cycle without MemReady; width ceil(log2(MAX_WAIT+1)).
REQ-023 When the counter equals MAX_WAIT-1 and MemReady is low, the transaction SHALL time out: MemReq drops, state -> IDLE, owner's Done and Err pulse next cycle, RData unchanged.
REQ-024 If MemReady and the timeout condition coincide, MemReady SHALL win (normal completion, no Err).
REQ-025 A requester dropping Req while in BUSY SHALL NOT abort the transaction; Done still pulses.
REQ-026 Requesters SHALL hold Req until their Done; Req still high in the cycle Done is asserted (IDLE) SHALL be treated as a new request.
REQ-027 No requester SHALL wait more than one other transaction while its Req is held (starvation bound).
REQ-028 Done, Err SHALL never be high in two consecutive cycles for the same transaction.

Reset
REQ-029 With RST high at a rising edge, next cycle: state IDLE, MemReq=0, MemWe=0, MemAddr=0, MemWData=0, CpuDone=LdrDone=Err=0, CpuRData=LdrRData=0, counter=0, owner=0, last-granted=1 (CPU wins first tie).
REQ-030 RST asserted in BUSY SHALL abort the transaction with no Done or Err pulse.

Verification
REQ-031 CPU read alone, MemReady 3 cycles after MemReq, MemRData=0xDEADBEEF -> CpuDone pulse one cycle after MemReady, CpuRData=0xDEADBEEF, LdrDone stays 0.
REQ-032 CpuReq and LdrReq both high from reset -> CPU served first, then loader immediately after; second tie after that grants CPU again (alternation).
REQ-033 Loader write Addr=0x40 Data=0x12345678, zero-wait memory -> MemWe=1, MemAddr=0x40, MemWData=0x12345678 for one cycle, LdrDone at n+2, LdrRData unchanged.
REQ-034 MemReady never asserted, MAX_WAIT=15 -> MemReq high exactly 15 cycles, then CpuDone and Err pulse together; MemReady on the 15th BUSY cycle instead -> no Err.
REQ-035 RST pulsed in second BUSY cycle -> MemReq 0 next cycle, no Done/Err, all outputs at reset values; new CpuReq afterwards completes normally.
REQ-036 CpuReq dropped mid-BUSY -> transaction completes, CpuDone pulses; CpuStall tracks CpuReq & ~CpuDone throughout.
